// File: rtl/decode_stage_if.sv
// Decoded-op record types and the fetch/decode handshake bundle shared by
// decode_stage and its neighbours.
package OpTypes;

    typedef enum logic [2:0] {
        TYPE_NONE, TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J, TYPE_JALR
    } OpType;

    typedef enum logic [2:0] {
        BR_NONE, BR_JUMP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } BrCtrl;

    typedef struct packed {
        OpType      opType;
        BrCtrl      brCtrl;
        logic       isBubble;
        logic       wEnable;
        logic       isForwardable;
        logic       isBranch;
        logic       isStore;
        logic       isLoad;
        logic       isLoadUnsigned;
        logic [1:0] memAccessWidth;
        logic       isMulDiv;
        logic [2:0] mulDivCode;
    } OpInfo;

    localparam OpInfo OP_BUBBLE = '{opType: TYPE_NONE, brCtrl: BR_NONE, isBubble: 1'b1,
                                    wEnable: 1'b0, isForwardable: 1'b0, isBranch: 1'b0,
                                    isStore: 1'b0, isLoad: 1'b0, isLoadUnsigned: 1'b0,
                                    memAccessWidth: 2'd0, isMulDiv: 1'b0, mulDivCode: 3'd0};

    localparam OpInfo OP_NONE = '{opType: TYPE_NONE, brCtrl: BR_NONE, isBubble: 1'b0,
                                  wEnable: 1'b0, isForwardable: 1'b0, isBranch: 1'b0,
                                  isStore: 1'b0, isLoad: 1'b0, isLoadUnsigned: 1'b0,
                                  memAccessWidth: 2'd0, isMulDiv: 1'b0, mulDivCode: 3'd0};

endpackage

interface decode_stage_if #(parameter int XLEN = 32);
    logic                ifValid;
    logic [31:0]         ifInstr;
    logic [XLEN-1:0]     ifPc;
    logic                ifReady;
    logic                flush;
    logic                idValid;
    logic                idReady;
    OpTypes::OpInfo      idOpInfo;
    logic [XLEN-1:0]     idPc;
    logic [4:0]          idRs1;
    logic [4:0]          idRs2;
    logic [4:0]          idRd;
    logic [31:0]         idImm;
    logic                idIllegal;

    modport master (
        output ifValid, ifInstr, ifPc, flush, idReady,
        input  ifReady, idValid, idOpInfo, idPc, idRs1, idRs2, idRd, idImm, idIllegal
    );

    modport slave (
        input  ifValid, ifInstr, ifPc, flush, idReady,
        output ifReady, idValid, idOpInfo, idPc, idRs1, idRs2, idRd, idImm, idIllegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32IM decode stage: combinational decode of the fetched word, captured into a
// main/skid output register pair so that ifReady comes straight from a flop.
module decode_stage
    import OpTypes::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BR     = 7'b1100011;
    localparam logic [6:0] OPC_ST     = 7'b0100011;
    localparam logic [6:0] OPC_LD     = 7'b0000011;

    typedef struct packed {
        OpInfo           op;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        entry_t             e;
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [31:0] immI;
        logic signed [31:0] immS;
        logic signed [31:0] immB;
        logic signed [31:0] immU;
        logic signed [31:0] immJ;

        opc  = instr[6:0];
        f3   = instr[14:12];
        f7   = instr[31:25];
        immI = {{20{instr[31]}}, instr[31:20]};
        immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        immU = {instr[31:12], 12'b0};
        immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

        e         = '0;
        e.op      = OP_NONE;
        e.pc      = pc;
        e.rs1     = instr[19:15];
        e.rs2     = instr[24:20];
        e.rd      = instr[11:7];

        case (opc)
            OPC_OP: begin
                e.op.opType        = TYPE_R;
                e.op.wEnable       = 1'b1;
                e.op.isForwardable = 1'b1;
                if (f7 == 7'b0000001) begin
                    e.op.isMulDiv      = 1'b1;
                    e.op.isForwardable = 1'b0;
                    e.op.mulDivCode    = f3;
                end else if (f7 != 7'b0000000 && f7 != 7'b0100000) begin
                    e.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                e.op.opType        = TYPE_I;
                e.op.wEnable       = 1'b1;
                e.op.isForwardable = 1'b1;
                e.imm              = immI;
            end
            OPC_LUI, OPC_AUIPC: begin
                e.op.opType        = TYPE_U;
                e.op.wEnable       = 1'b1;
                e.op.isForwardable = 1'b1;
                e.imm              = immU;
            end
            OPC_JAL: begin
                e.op.opType   = TYPE_J;
                e.op.brCtrl   = BR_JUMP;
                e.op.isBranch = 1'b1;
                e.op.wEnable  = 1'b1;
                e.imm         = immJ;
            end
            OPC_JALR: begin
                e.op.opType   = TYPE_JALR;
                e.op.brCtrl   = BR_JUMP;
                e.op.isBranch = 1'b1;
                e.op.wEnable  = 1'b1;
                e.imm         = immI;
                e.illegal     = (f3 != 3'b000);
            end
            OPC_BR: begin
                e.op.opType   = TYPE_B;
                e.op.isBranch = 1'b1;
                e.imm         = immB;
                case (f3)
                    3'b000:  e.op.brCtrl = BR_EQ;
                    3'b001:  e.op.brCtrl = BR_NE;
                    3'b100:  e.op.brCtrl = BR_LT;
                    3'b101:  e.op.brCtrl = BR_GE;
                    3'b110:  e.op.brCtrl = BR_LTU;
                    3'b111:  e.op.brCtrl = BR_GEU;
                    default: e.illegal   = 1'b1;
                endcase
            end
            OPC_ST: begin
                e.op.opType         = TYPE_S;
                e.op.isStore        = 1'b1;
                e.op.memAccessWidth = f3[1:0];
                e.imm               = immS;
                e.illegal           = (f3 > 3'd2);
            end
            OPC_LD: begin
                e.op.opType         = TYPE_I;
                e.op.isLoad         = 1'b1;
                e.op.wEnable        = 1'b1;
                e.op.isLoadUnsigned = f3[2];
                e.op.memAccessWidth = f3[1:0];
                e.imm               = immI;
                e.illegal           = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            default: e.illegal = 1'b1;
        endcase

        if (e.rd == 5'd0) begin
            e.op.wEnable       = 1'b0;
            e.op.isForwardable = 1'b0;
        end
        // Illegal encodings travel as inert ops so downstream can raise the trap.
        if (e.illegal) begin
            e.op  = OP_NONE;
            e.imm = '0;
        end
        return e;
    endfunction

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   mainValid_q, mainValid_d;
    logic   skidValid_q, skidValid_d;
    logic   ifReady_q, ifReady_d;
    logic   accept;
    entry_t newEntry;

    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        accept      = bus.ifValid && ifReady_q && !bus.flush;
        newEntry    = decode(bus.ifInstr, bus.ifPc);

        if (bus.flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (!mainValid_q || bus.idReady) begin
            // ifReady_q is low whenever skid is occupied, so accept and a skid
            // refill never coincide here.
            if (skidValid_q) begin
                main_d      = skid_q;
                mainValid_d = 1'b1;
                skidValid_d = 1'b0;
            end else begin
                mainValid_d = accept;
                if (accept) begin
                    main_d = newEntry;
                end
            end
        end else if (accept) begin
            skid_d      = newEntry;
            skidValid_d = 1'b1;
        end

        ifReady_d = !skidValid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            ifReady_q   <= 1'b0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            ifReady_q   <= ifReady_d;
        end
    end

    assign bus.ifReady   = ifReady_q;
    assign bus.idValid   = mainValid_q;
    assign bus.idOpInfo  = mainValid_q ? main_q.op : OP_BUBBLE;
    assign bus.idPc      = main_q.pc;
    assign bus.idRs1     = main_q.rs1;
    assign bus.idRs2     = main_q.rs2;
    assign bus.idRd      = main_q.rd;
    assign bus.idImm     = main_q.imm;
    assign bus.idIllegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plan followed by random traffic, checked
// against an ISA-level decode model and a two-deep in-order occupancy queue.
module tb_decode_stage;
    import OpTypes::*;

    typedef struct {
        OpInfo       op;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();
    decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        q[$];
    logic [31:0] emerged[$];
    bit          mrdy = 1'b0;
    bit          logEmerged = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkOp(input string tag, input OpInfo obs, input OpInfo exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ISA-level reference: field extraction with arithmetic shifts on the whole word.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t  e;
        int    si;
        int    imm;
        bit    bad;
        BrCtrl brTab[8];
        brTab = '{BR_EQ, BR_NE, BR_NONE, BR_NONE, BR_LT, BR_GE, BR_LTU, BR_GEU};
        si  = $signed(i);
        imm = 0;
        bad = 1'b0;
        e.op = OP_NONE;
        e.pc = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        case (i[6:0])
            7'h33: begin
                e.op.opType = TYPE_R; e.op.wEnable = 1'b1; e.op.isForwardable = 1'b1;
                if (i[31:25] == 7'h01) begin
                    e.op.isMulDiv = 1'b1; e.op.isForwardable = 1'b0; e.op.mulDivCode = i[14:12];
                end else if (i[31:25] != 7'h00 && i[31:25] != 7'h20) bad = 1'b1;
            end
            7'h13: begin
                e.op.opType = TYPE_I; e.op.wEnable = 1'b1; e.op.isForwardable = 1'b1;
                imm = si >>> 20;
            end
            7'h37, 7'h17: begin
                e.op.opType = TYPE_U; e.op.wEnable = 1'b1; e.op.isForwardable = 1'b1;
                imm = si & 32'hFFFFF000;
            end
            7'h6F: begin
                e.op.opType = TYPE_J; e.op.brCtrl = BR_JUMP; e.op.isBranch = 1'b1; e.op.wEnable = 1'b1;
                imm = ((si >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
            end
            7'h67: begin
                e.op.opType = TYPE_JALR; e.op.brCtrl = BR_JUMP; e.op.isBranch = 1'b1; e.op.wEnable = 1'b1;
                imm = si >>> 20;
                bad = (i[14:12] != 0);
            end
            7'h63: begin
                e.op.opType = TYPE_B; e.op.isBranch = 1'b1; e.op.brCtrl = brTab[i[14:12]];
                imm = ((si >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
                bad = (brTab[i[14:12]] == BR_NONE);
            end
            7'h23: begin
                e.op.opType = TYPE_S; e.op.isStore = 1'b1; e.op.memAccessWidth = i[13:12];
                imm = ((si >>> 25) << 5) | int'(i[11:7]);
                bad = (i[14:12] > 2);
            end
            7'h03: begin
                e.op.opType = TYPE_I; e.op.isLoad = 1'b1; e.op.wEnable = 1'b1;
                e.op.memAccessWidth = i[13:12];
                e.op.isLoadUnsigned = (i[14:12] == 4 || i[14:12] == 5);
                imm = si >>> 20;
                bad = !(i[14:12] == 0 || i[14:12] == 1 || i[14:12] == 2 || i[14:12] == 4 || i[14:12] == 5);
            end
            default: bad = 1'b1;
        endcase
        if (e.rd == 0) begin
            e.op.wEnable = 1'b0;
            e.op.isForwardable = 1'b0;
        end
        if (bad) begin
            e.op = OP_NONE;
            imm = 0;
        end
        e.imm = imm;
        e.ill = bad;
        return e;
    endfunction

    task automatic check_outputs();
        chk32("idValid", 32'(bus.idValid), 32'(q.size() > 0));
        chk32("ifReady", 32'(bus.ifReady), 32'(mrdy));
        if (q.size() > 0) begin
            chkOp("idOpInfo", bus.idOpInfo, q[0].op);
            chk32("idPc", bus.idPc, q[0].pc);
            chk32("idRs1", 32'(bus.idRs1), 32'(q[0].rs1));
            chk32("idRs2", 32'(bus.idRs2), 32'(q[0].rs2));
            chk32("idRd", 32'(bus.idRd), 32'(q[0].rd));
            chk32("idImm", bus.idImm, q[0].imm);
            chk32("idIllegal", 32'(bus.idIllegal), 32'(q[0].ill));
        end else begin
            chkOp("bubble", bus.idOpInfo, OP_BUBBLE);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic r, output bit acc);
        bit cons;
        rst         = r;
        bus.ifValid = v;
        bus.ifInstr = ins;
        bus.ifPc    = pc;
        bus.idReady = rdy;
        bus.flush   = fl;
        acc  = !r && v && mrdy && !fl;
        cons = !r && !fl && (q.size() > 0) && rdy;
        if (logEmerged && bus.idValid && rdy) emerged.push_back(bus.idPc);
        @(posedge clk);
        if (r) begin
            q.delete();
            mrdy = 1'b0;
        end else if (fl) begin
            q.delete();
            mrdy = 1'b1;
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, pc));
            mrdy = (q.size() < 2);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bit          a;
        logic [31:0] pc;
        logic [31:0] ins;
        int          k;
        logic [6:0]  opcs[11];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03, 7'h7F, 7'h0B};

        // Reset held two cycles with a valid instruction presented
        step(1, 32'hFFF08293, 32'h100, 1, 0, 1, a);
        step(1, 32'hFFF08293, 32'h100, 1, 0, 1, a);
        chk32("rst_ifReady", 32'(bus.ifReady), 32'd0);
        chk32("rst_isBubble", 32'(bus.idOpInfo.isBubble), 32'd1);
        chk32("rst_idPc", bus.idPc, 32'd0);
        chk32("rst_idImm", bus.idImm, 32'd0);
        chk32("rst_idRd", 32'(bus.idRd), 32'd0);
        chk32("rst_idIllegal", 32'(bus.idIllegal), 32'd0);
        step(0, 32'h0, 32'h0, 1, 0, 0, a);
        chk32("post_rst_ifReady", 32'(bus.ifReady), 32'd1);

        // Directed decodes
        step(1, 32'hFFF08293, 32'h100, 1, 0, 0, a);
        chk32("addi_type", 32'(bus.idOpInfo.opType), 32'(TYPE_I));
        chk32("addi_imm", bus.idImm, 32'hFFFFFFFF);
        chk32("addi_rd", 32'(bus.idRd), 32'd5);
        chk32("addi_wen", 32'(bus.idOpInfo.wEnable), 32'd1);
        chk32("addi_pc", bus.idPc, 32'h100);
        step(1, 32'hFE316CE3, 32'h104, 1, 0, 0, a);
        chk32("bltu_br", 32'(bus.idOpInfo.brCtrl), 32'(BR_LTU));
        chk32("bltu_imm", bus.idImm, 32'hFFFFFFF8);
        chk32("bltu_wen", 32'(bus.idOpInfo.wEnable), 32'd0);
        step(1, 32'h0000C003, 32'h108, 1, 0, 0, a);
        chk32("lbu_unsigned", 32'(bus.idOpInfo.isLoadUnsigned), 32'd1);
        chk32("lbu_wen", 32'(bus.idOpInfo.wEnable), 32'd0);
        step(1, 32'h0000007F, 32'h10C, 1, 0, 0, a);
        chk32("ill_opc", 32'(bus.idIllegal), 32'd1);
        step(1, 32'h00002063, 32'h110, 1, 0, 0, a);
        chk32("ill_br_type", 32'(bus.idOpInfo.opType), 32'(TYPE_NONE));
        chk32("ill_br_flag", 32'(bus.idIllegal), 32'd1);
        step(0, 32'h0, 32'h0, 1, 0, 0, a);

        // Back-pressure: four instructions, consumer stalled for three cycles
        logEmerged = 1'b1;
        emerged.delete();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            pc = 32'h200 + 32'(k * 4);
            step(k < 4, 32'h00100093 + (32'(k) << 7), pc, c >= 3, 0, 0, a);
            if (a) k++;
            if (c == 1) chk32("bp_ifReady_low", 32'(bus.ifReady), 32'd0);
        end
        logEmerged = 1'b0;
        chk32("bp_count", 32'(emerged.size()), 32'd4);
        for (int j = 0; j < 4 && j < emerged.size(); j++)
            chk32("bp_order", emerged[j], 32'h200 + 32'(j * 4));

        // Flush with skid full, valid input and consumer ready together
        step(1, 32'h00500113, 32'h300, 0, 0, 0, a);
        step(1, 32'h00600193, 32'h304, 0, 0, 0, a);
        step(1, 32'h00700213, 32'h308, 1, 1, 0, a);
        chk32("flush_idValid", 32'(bus.idValid), 32'd0);
        chk32("flush_ifReady", 32'(bus.ifReady), 32'd1);
        for (int c = 0; c < 3; c++) step(0, 32'h0, 32'h0, 1, 0, 0, a);

        // Random traffic
        pc = 32'h1000;
        for (int c = 0; c < 600; c++) begin
            ins = ($urandom & 32'hFFFFFF80) | 32'(opcs[$urandom_range(0, 10)]);
            step($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, 0, a);
            if (a) pc += 4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
